// File: rtl/axi_burst_bridge_if.sv
// AXI3 master-side bus bundle used by the cache burst bridge.
// The bridge connects through the master modport; a slave model uses the slave modport.
interface axi_burst_bridge_if #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  localparam int STRB_W = DATA_W / 8;

  logic [ID_W-1:0]   arid;
  logic [31:0]       araddr;
  logic [3:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [1:0]        arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  logic [ID_W-1:0]   awid;
  logic [31:0]       awaddr;
  logic [3:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [1:0]        awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;

  logic [ID_W-1:0]   wid;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_burst_bridge.sv
// Cache-to-AXI3 burst bridge: one INCR/WRAP read or write burst in flight at a time,
// with beat streaming in both directions and the AXI error response folded into mem_err.
module axi_burst_bridge #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4,
  parameter int AXI_ID = 0,
  parameter int ID_W   = 4,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_req,
  output logic              mem_ready,
  input  logic              mem_write,
  input  logic [31:0]       mem_addr,
  input  logic [LEN_W-1:0]  mem_len,
  input  logic [2:0]        mem_size,
  input  logic              mem_wrap,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_wvalid,
  output logic              mem_wready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rvalid,
  output logic              mem_rlast,
  output logic              mem_done,
  output logic              mem_err,
  axi_burst_bridge_if.master axi
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP} state_t;

  state_t            state_reg, state_next;
  logic [31:0]       addr_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  cnt_reg;
  logic [2:0]        size_reg;
  logic [1:0]        burst_reg;
  logic              aw_done_reg;
  logic              w_done_reg;
  logic              err_reg;

  logic [3:0]        req_len4;
  logic              wrap_ok;
  logic              rd_last;
  logic              aw_hs;
  logic              w_hs;
  logic              w_last;
  wire               unused_ids = ^{axi.rid, axi.bid};

  // WRAP is only legal for 2/4/8/16 beats; anything else falls back to INCR
  assign req_len4 = 4'(mem_len);
  assign wrap_ok  = (req_len4 == 4'd1) || (req_len4 == 4'd3) ||
                    (req_len4 == 4'd7) || (req_len4 == 4'd15);

  // The counter covers a slave that never asserts rlast
  assign rd_last = axi.rlast || (cnt_reg == len_reg);
  assign w_last  = (cnt_reg == len_reg);
  assign aw_hs   = (state_reg == WR) && !aw_done_reg && axi.awready;
  assign w_hs    = (state_reg == WR) && mem_wvalid && !w_done_reg && axi.wready;

  assign axi.arid    = ID_W'(AXI_ID);
  assign axi.awid    = ID_W'(AXI_ID);
  assign axi.wid     = ID_W'(AXI_ID);
  assign axi.araddr  = addr_reg;
  assign axi.awaddr  = addr_reg;
  assign axi.arlen   = 4'(len_reg);
  assign axi.awlen   = 4'(len_reg);
  assign axi.arsize  = size_reg;
  assign axi.awsize  = size_reg;
  assign axi.arburst = burst_reg;
  assign axi.awburst = burst_reg;
  assign axi.arlock  = 2'b00;
  assign axi.awlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.awcache = 4'b0000;
  assign axi.arprot  = 3'b000;
  assign axi.awprot  = 3'b000;
  assign axi.wdata   = mem_wdata;
  assign axi.wstrb   = mem_wstrb;
  assign axi.wlast   = w_last;
  assign mem_rdata   = axi.rdata;
  assign mem_wready  = w_hs;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    mem_ready   = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rlast   = 1'b0;
    mem_done    = 1'b0;
    mem_err     = 1'b0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    case (state_reg)
      IDLE: begin
        mem_ready = mem_req;
        if (mem_req) state_next = mem_write ? WR : RD_ADDR;
      end
      RD_ADDR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) state_next = RD_DATA;
      end
      RD_DATA: begin
        axi.rready = 1'b1;
        mem_rvalid = axi.rvalid;
        mem_rlast  = axi.rvalid && rd_last;
        if (axi.rvalid && rd_last) begin
          mem_done   = 1'b1;
          mem_err    = err_reg || (axi.rresp != 2'b00);
          state_next = IDLE;
        end
      end
      WR: begin
        axi.awvalid = !aw_done_reg;
        axi.wvalid  = mem_wvalid && !w_done_reg;
        if ((aw_done_reg || aw_hs) && (w_done_reg || (w_hs && w_last)))
          state_next = WR_RESP;
      end
      WR_RESP: begin
        axi.bready = 1'b1;
        if (axi.bvalid) begin
          mem_done   = 1'b1;
          mem_err    = (axi.bresp != 2'b00);
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_reg    <= '0;
      len_reg     <= '0;
      cnt_reg     <= '0;
      size_reg    <= '0;
      burst_reg   <= '0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (mem_req) begin
            addr_reg    <= mem_addr;
            len_reg     <= mem_len;
            size_reg    <= mem_size;
            burst_reg   <= (mem_wrap && wrap_ok) ? 2'b10 : 2'b01;
            cnt_reg     <= '0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            err_reg     <= 1'b0;
          end
        end
        RD_DATA: begin
          if (axi.rvalid) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (axi.rresp != 2'b00) err_reg <= 1'b1;
          end
        end
        WR: begin
          if (aw_hs) aw_done_reg <= 1'b1;
          if (w_hs) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (w_last) w_done_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
